// File: rtl/core_config_pkg.sv
// core_config_pkg: shared core types and constants used by the branch resolve slice
package core_config_pkg;
    typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} branch_resolve_state_t;
    localparam logic [1:0] BHT_INIT = 2'b01;
    localparam int IF_INC = 4;
endpackage

// File: rtl/branch_resolve_if.sv
// branch_resolve_if: ALU result, register-file, redirect, exception and predictor signals of branch_resolve
interface branch_resolve_if #(
    parameter int XLEN = 32,
    parameter int REG_ADDR_W = 5
);
    logic alu_valid;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] alu_jmp;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic alu_req;
    logic alu_mispredict;
    logic alu_o_error;
    logic alu_i_error;
    logic [XLEN-1:0] br_pc;
    logic br_is_cond;
    logic alu_clear;
    logic busy;
    logic rf_we;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic redir_valid;
    logic [XLEN-1:0] redir_pc;
    logic redir_ready;
    logic flush;
    logic exc_valid;
    logic [XLEN-1:0] exc_pc;
    logic [XLEN-1:0] pred_pc;
    logic pred_taken;

    modport master (
        output alu_valid, alu_res, alu_jmp, alu_rd, alu_req, alu_mispredict,
               alu_o_error, alu_i_error, br_pc, br_is_cond, redir_ready, pred_pc,
        input  alu_clear, busy, rf_we, rf_waddr, rf_wdata, redir_valid, redir_pc,
               flush, exc_valid, exc_pc, pred_taken
    );

    modport slave (
        input  alu_valid, alu_res, alu_jmp, alu_rd, alu_req, alu_mispredict,
               alu_o_error, alu_i_error, br_pc, br_is_cond, redir_ready, pred_pc,
        output alu_clear, busy, rf_we, rf_waddr, rf_wdata, redir_valid, redir_pc,
               flush, exc_valid, exc_pc, pred_taken
    );
endinterface

// File: rtl/branch_resolve_bht.sv
// bht: 2-bit saturating counter table with one combinational read and one synchronous update
module bht
    import core_config_pkg::*;
#(
    parameter int ENTRIES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic [$clog2(ENTRIES)-1:0] rd_idx,
    output logic rd_taken,
    input  logic wr_en,
    input  logic [$clog2(ENTRIES)-1:0] wr_idx,
    input  logic wr_taken
);
    logic [1:0] ctr [ENTRIES];

    // counters saturate at 0 and 3; reset to weakly not-taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= BHT_INIT;
        end else if (wr_en) begin
            ctr[wr_idx] <= wr_taken ? (ctr[wr_idx] == 2'd3 ? 2'd3 : ctr[wr_idx] + 2'd1)
                                    : (ctr[wr_idx] == 2'd0 ? 2'd0 : ctr[wr_idx] - 2'd1);
        end
    end

    assign rd_taken = ctr[rd_idx][1];
endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: commits branch ALU results, trains the BHT, redirects fetch and flushes
module branch_resolve
    import core_config_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int REG_ADDR_W = 5,
    parameter int BHT_ENTRIES = 64,
    parameter int FLUSH_CYCLES = 2
) (
    input logic clk,
    input logic rst_n,
    branch_resolve_if.slave bus
);
    localparam int IW = $clog2(BHT_ENTRIES);
    localparam int CW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;

    branch_resolve_state_t state, state_nx;
    logic [CW-1:0] fcnt;
    logic acc, err, ok, wr;

    assign acc = state == IDLE && bus.alu_valid;
    assign err = bus.alu_o_error | bus.alu_i_error;
    assign ok = acc && !err;
    assign wr = ok && |bus.alu_rd;

    // next state: errors flush directly, mispredicts redirect first
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = !acc ? IDLE : err ? FLUSH : bus.alu_mispredict ? REDIRECT : IDLE;
            REDIRECT: state_nx = bus.redir_ready ? FLUSH : REDIRECT;
            FLUSH:    state_nx = fcnt == CW'(FLUSH_CYCLES - 1) ? IDLE : FLUSH;
            default:  state_nx = IDLE;
        endcase
    end

    // state register and flush-length counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            fcnt <= '0;
        end else begin
            state <= state_nx;
            fcnt <= state == FLUSH ? fcnt + CW'(1) : '0;
        end
    end

    // registered outputs, all derived from this cycle's acceptance and next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.alu_clear <= 1'b0;
            bus.busy <= 1'b0;
            bus.rf_we <= 1'b0;
            bus.rf_waddr <= '0;
            bus.rf_wdata <= '0;
            bus.redir_valid <= 1'b0;
            bus.redir_pc <= '0;
            bus.flush <= 1'b0;
            bus.exc_valid <= 1'b0;
            bus.exc_pc <= '0;
        end else begin
            bus.alu_clear <= acc;
            bus.busy <= state_nx != IDLE;
            bus.rf_we <= wr;
            bus.redir_valid <= state_nx == REDIRECT;
            bus.flush <= state_nx == FLUSH;
            bus.exc_valid <= acc && err;
            if (wr) begin
                bus.rf_waddr <= bus.alu_rd;
                bus.rf_wdata <= bus.alu_res;
            end
            if (ok && bus.alu_mispredict)
                bus.redir_pc <= bus.alu_req ? bus.alu_jmp : bus.br_pc + XLEN'(IF_INC);
            if (acc && err) bus.exc_pc <= bus.br_pc;
        end
    end

    bht #(.ENTRIES(BHT_ENTRIES)) u_bht (
        .clk(clk),
        .rst_n(rst_n),
        .rd_idx(bus.pred_pc[IW+1:2]),
        .rd_taken(bus.pred_taken),
        .wr_en(ok && bus.br_is_cond),
        .wr_idx(bus.br_pc[IW+1:2]),
        .wr_taken(bus.alu_req)
    );
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed and randomized checks of branch_resolve against a behavioural model
module tb_branch_resolve;
    localparam int XLEN = 32;
    localparam int RW = 5;
    localparam int ENT = 64;
    localparam int FC = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    int bht_m [ENT];

    always #5 clk = ~clk;

    branch_resolve_if #(.XLEN(XLEN), .REG_ADDR_W(RW)) bus ();

    branch_resolve #(.XLEN(XLEN), .REG_ADDR_W(RW), .BHT_ENTRIES(ENT), .FLUSH_CYCLES(FC)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    function automatic int idx_of(input logic [31:0] pc);
        return int'(pc[7:2]);
    endfunction

    function automatic void train(input int i, input bit t);
        bht_m[i] = t ? (bht_m[i] < 3 ? bht_m[i] + 1 : 3) : (bht_m[i] > 0 ? bht_m[i] - 1 : 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.alu_valid = 0; bus.alu_res = 0; bus.alu_jmp = 0; bus.alu_rd = 0;
        bus.alu_req = 0; bus.alu_mispredict = 0; bus.alu_o_error = 0; bus.alu_i_error = 0;
        bus.br_pc = 0; bus.br_is_cond = 0; bus.redir_ready = 0;
    endtask

    task automatic set_in(input logic [4:0] rd, input logic [31:0] res, jmp, pc,
                          input logic req, mis, oe, ie, cond);
        bus.alu_valid = 1; bus.alu_rd = rd; bus.alu_res = res; bus.alu_jmp = jmp; bus.br_pc = pc;
        bus.alu_req = req; bus.alu_mispredict = mis; bus.alu_o_error = oe; bus.alu_i_error = ie;
        bus.br_is_cond = cond;
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_in();
        bus.pred_pc = 32'h100;
        for (int i = 0; i < ENT; i++) bht_m[i] = 1;
        tick(); tick();
        n_cmp++; if ({bus.alu_clear, bus.busy, bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.redir_valid, bus.redir_pc, bus.flush, bus.exc_valid, bus.exc_pc} !== '0) begin n_bad++; $display("FAIL reset_outs_in_reset: got nonzero outputs, want 0"); end
        rst_n = 1;
        tick();
        n_cmp++; if ({bus.alu_clear, bus.rf_we, bus.redir_valid, bus.flush, bus.exc_valid} !== 5'b0) begin n_bad++; $display("FAIL reset_outs: got %b want 00000", {bus.alu_clear, bus.rf_we, bus.redir_valid, bus.flush, bus.exc_valid}); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.pred_taken !== 1'b0) begin n_bad++; $display("FAIL reset_pred: got %b want 0", bus.pred_taken); end
    endtask

    task automatic test_writeback();
        set_in(5'd5, 32'd1, 32'h0, 32'h10, 0, 0, 0, 0, 0);
        tick();
        n_cmp++; if (bus.rf_we !== 1'b1) begin n_bad++; $display("FAIL wb_we: got %b want 1", bus.rf_we); end
        n_cmp++; if (bus.rf_waddr !== 5'd5) begin n_bad++; $display("FAIL wb_addr: got %0d want 5", bus.rf_waddr); end
        n_cmp++; if (bus.rf_wdata !== 32'd1) begin n_bad++; $display("FAIL wb_data: got %0h want 1", bus.rf_wdata); end
        n_cmp++; if (bus.alu_clear !== 1'b1) begin n_bad++; $display("FAIL wb_clear: got %b want 1", bus.alu_clear); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL wb_busy: got %b want 0", bus.busy); end
        set_in(5'd0, 32'hdead, 32'h0, 32'h14, 0, 0, 0, 0, 0);
        tick();
        n_cmp++; if (bus.rf_we !== 1'b0 || bus.alu_clear !== 1'b1) begin n_bad++; $display("FAIL wb_x0: got we=%b clr=%b want we=0 clr=1", bus.rf_we, bus.alu_clear); end
        clear_in();
        tick();
        n_cmp++; if (bus.rf_we !== 1'b0 || bus.alu_clear !== 1'b0) begin n_bad++; $display("FAIL wb_pulse: got we=%b clr=%b want 0 0", bus.rf_we, bus.alu_clear); end
    endtask

    task automatic test_redirect_hold();
        set_in(5'd7, 32'haa, 32'h9999, 32'h200, 0, 1, 0, 0, 0);
        tick();
        n_cmp++; if (bus.redir_valid !== 1'b1 || bus.redir_pc !== 32'h204) begin n_bad++; $display("FAIL redir_first: got v=%b pc=%0h want 1 204", bus.redir_valid, bus.redir_pc); end
        n_cmp++; if (bus.busy !== 1'b1 || bus.rf_we !== 1'b1) begin n_bad++; $display("FAIL redir_busy_we: got busy=%b we=%b want 1 1", bus.busy, bus.rf_we); end
        set_in(5'd9, 32'hbb, 32'h1234, 32'h600, 1, 1, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (bus.redir_valid !== 1'b1 || bus.redir_pc !== 32'h204 || bus.alu_clear !== 1'b0) begin n_bad++; $display("FAIL redir_hold%0d: got v=%b pc=%0h clr=%b want 1 204 0", k, bus.redir_valid, bus.redir_pc, bus.alu_clear); end
        end
        bus.redir_ready = 1;
        for (int k = 0; k < FC; k++) begin
            tick();
            n_cmp++; if (bus.flush !== 1'b1 || bus.redir_valid !== 1'b0) begin n_bad++; $display("FAIL redir_flush%0d: got f=%b v=%b want 1 0", k, bus.flush, bus.redir_valid); end
        end
        clear_in();
        tick();
        n_cmp++; if (bus.flush !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL redir_done: got f=%b busy=%b want 0 0", bus.flush, bus.busy); end
    endtask

    task automatic test_jalr();
        set_in(5'd1, 32'h1004, 32'h8000, 32'h1000, 1, 1, 0, 0, 0);
        bus.redir_ready = 1;
        tick();
        n_cmp++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd1 || bus.rf_wdata !== 32'h1004) begin n_bad++; $display("FAIL jalr_wb: got we=%b a=%0d d=%0h want 1 1 1004", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        n_cmp++; if (bus.redir_valid !== 1'b1 || bus.redir_pc !== 32'h8000) begin n_bad++; $display("FAIL jalr_redir: got v=%b pc=%0h want 1 8000", bus.redir_valid, bus.redir_pc); end
        clear_in();
        bus.redir_ready = 1;
        for (int k = 0; k < FC; k++) begin
            tick();
            n_cmp++; if (bus.flush !== 1'b1) begin n_bad++; $display("FAIL jalr_flush%0d: got %b want 1", k, bus.flush); end
        end
        bus.redir_ready = 0;
        tick();
        n_cmp++; if (bus.flush !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL jalr_done: got f=%b busy=%b want 0 0", bus.flush, bus.busy); end
    endtask

    task automatic test_bht_training();
        bit seq [9] = '{1, 1, 1, 0, 0, 0, 0, 1, 1};
        bit want [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 1};
        bus.pred_pc = 32'h40;
        for (int k = 0; k < 9; k++) begin
            set_in(5'd0, 32'h0, 32'h0, 32'h40, seq[k], 0, 0, 0, 1);
            tick();
            train(idx_of(32'h40), seq[k]);
            clear_in();
            #1;
            n_cmp++; if (bus.pred_taken !== want[k]) begin n_bad++; $display("FAIL bht_step%0d: got %b want %b", k, bus.pred_taken, want[k]); end
        end
    endtask

    task automatic test_error();
        set_in(5'd3, 32'h55, 32'h0, 32'h300, 1, 0, 1, 0, 1);
        tick();
        bus.pred_pc = 32'h300;
        n_cmp++; if (bus.exc_valid !== 1'b1 || bus.exc_pc !== 32'h300) begin n_bad++; $display("FAIL err_exc: got v=%b pc=%0h want 1 300", bus.exc_valid, bus.exc_pc); end
        n_cmp++; if (bus.rf_we !== 1'b0 || bus.redir_valid !== 1'b0 || bus.flush !== 1'b1) begin n_bad++; $display("FAIL err_side: got we=%b rv=%b f=%b want 0 0 1", bus.rf_we, bus.redir_valid, bus.flush); end
        #1;
        n_cmp++; if (bus.pred_taken !== 1'b0) begin n_bad++; $display("FAIL err_bht: got %b want 0", bus.pred_taken); end
        clear_in();
        for (int k = 1; k < FC; k++) begin
            tick();
            n_cmp++; if (bus.flush !== 1'b1 || bus.exc_valid !== 1'b0) begin n_bad++; $display("FAIL err_flush%0d: got f=%b e=%b want 1 0", k, bus.flush, bus.exc_valid); end
        end
        tick();
        n_cmp++; if (bus.flush !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL err_done: got f=%b busy=%b want 0 0", bus.flush, bus.busy); end
        set_in(5'd4, 32'h66, 32'h0, 32'h44, 0, 0, 0, 1, 0);
        tick();
        clear_in();
        bus.pred_pc = 32'h40;
        #2;
        rst_n = 0;
        #1;
        for (int i = 0; i < ENT; i++) bht_m[i] = 1;
        n_cmp++; if ({bus.alu_clear, bus.busy, bus.rf_we, bus.redir_valid, bus.flush, bus.exc_valid, bus.exc_pc, bus.redir_pc} !== '0) begin n_bad++; $display("FAIL err_async_reset: got nonzero outputs want 0"); end
        n_cmp++; if (bus.pred_taken !== 1'b0) begin n_bad++; $display("FAIL err_reset_bht: got %b want 0", bus.pred_taken); end
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_random(input int n);
        for (int it = 0; it < n; it++) begin
            logic [31:0] pc, res, jmp, epc, ppc;
            logic [4:0] rd;
            logic v, req, mis, oe, ie, cond, e_we, e_err, e_red;
            int lat;
            pc = 32'h1000 + ($urandom_range(0, 7) << 2);
            ppc = 32'h1000 + ($urandom_range(0, 7) << 2);
            res = $urandom; jmp = $urandom; rd = 5'($urandom_range(0, 31));
            v = $urandom_range(0, 7) != 0; req = 1'($urandom); mis = $urandom_range(0, 3) == 0;
            oe = $urandom_range(0, 11) == 0; ie = $urandom_range(0, 11) == 0; cond = 1'($urandom);
            lat = $urandom_range(0, 3);
            set_in(rd, res, jmp, pc, req, mis, oe, ie, cond);
            bus.alu_valid = v;
            bus.redir_ready = 1'($urandom);
            bus.pred_pc = ppc;
            #1;
            n_cmp++; if (bus.pred_taken !== (bht_m[idx_of(ppc)] >= 2)) begin n_bad++; $display("FAIL rnd_pred it%0d: got %b want %b", it, bus.pred_taken, bht_m[idx_of(ppc)] >= 2); end
            e_err = v && (oe || ie);
            e_we = v && !e_err && rd != 0;
            e_red = v && !e_err && mis;
            epc = req ? jmp : pc + 32'd4;
            if (v && !e_err && cond) train(idx_of(pc), req);
            tick();
            n_cmp++; if (bus.alu_clear !== v || bus.rf_we !== e_we || bus.exc_valid !== e_err) begin n_bad++; $display("FAIL rnd_acc it%0d: got clr=%b we=%b exc=%b want %b %b %b", it, bus.alu_clear, bus.rf_we, bus.exc_valid, v, e_we, e_err); end
            n_cmp++; if (bus.redir_valid !== e_red || bus.flush !== e_err || bus.busy !== (e_red || e_err)) begin n_bad++; $display("FAIL rnd_state it%0d: got rv=%b f=%b busy=%b want %b %b %b", it, bus.redir_valid, bus.flush, bus.busy, e_red, e_err, e_red || e_err); end
            if (e_we) begin
                n_cmp++; if (bus.rf_waddr !== rd || bus.rf_wdata !== res) begin n_bad++; $display("FAIL rnd_wb it%0d: got a=%0d d=%0h want %0d %0h", it, bus.rf_waddr, bus.rf_wdata, rd, res); end
            end
            if (e_err) begin
                n_cmp++; if (bus.exc_pc !== pc) begin n_bad++; $display("FAIL rnd_exc_pc it%0d: got %0h want %0h", it, bus.exc_pc, pc); end
            end
            if (e_red) begin
                n_cmp++; if (bus.redir_pc !== epc) begin n_bad++; $display("FAIL rnd_redir_pc it%0d: got %0h want %0h", it, bus.redir_pc, epc); end
            end
            set_in(5'($urandom), $urandom, $urandom, $urandom, 1'($urandom), 1, 1'($urandom), 0, 1);
            if (e_red) begin
                for (int k = 0; k < lat; k++) begin
                    bus.redir_ready = 0;
                    tick();
                    n_cmp++; if (bus.redir_valid !== 1'b1 || bus.redir_pc !== epc || bus.alu_clear !== 1'b0) begin n_bad++; $display("FAIL rnd_hold it%0d: got v=%b pc=%0h clr=%b want 1 %0h 0", it, bus.redir_valid, bus.redir_pc, bus.alu_clear, epc); end
                end
                bus.redir_ready = 1;
                tick();
                n_cmp++; if (bus.flush !== 1'b1 || bus.redir_valid !== 1'b0) begin n_bad++; $display("FAIL rnd_hs it%0d: got f=%b v=%b want 1 0", it, bus.flush, bus.redir_valid); end
            end
            if (e_red || e_err) begin
                for (int k = 1; k < FC; k++) begin
                    tick();
                    n_cmp++; if (bus.flush !== 1'b1 || bus.alu_clear !== 1'b0) begin n_bad++; $display("FAIL rnd_flush it%0d: got f=%b clr=%b want 1 0", it, bus.flush, bus.alu_clear); end
                end
                tick();
                n_cmp++; if (bus.flush !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL rnd_done it%0d: got f=%b busy=%b want 0 0", it, bus.flush, bus.busy); end
            end
        end
        clear_in();
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_writeback();
        test_redirect_hold();
        test_jalr();
        test_bht_training();
        test_error();
        test_random(400);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
